alu_word_seq: RTL and testbench
===============================

Name: alu_word_seq

Overview:
Two-cycle sequencer that runs 16-bit read-modify-write word ops (INW, DEW, ASW, ROW) through the shared 8-bit alu_unit, one byte per cycle, chaining carry between bytes. It sits between the microcode control and the ALU input muxes. While it owns the ALU it drives alu_own so the input muxes select its a/b/op/c_in. It returns the 16-bit result and N/Z/C flags with a single-cycle done pulse.

Parameters:
OP_ADC, `ALU_ADC, ALU op code driven for add-based steps (from 6502_inc.vh)
OP_ROR, `ALU_ROR, ALU op code driven for rotate steps (from 6502_inc.vh)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
wop  input  2  word op: 0=INW, 1=DEW, 2=ASW, 3=ROW
operand  input  16  word operand, captured on accepted start
c_in  input  1  processor C flag, captured on accepted start (used by ROW only)
alu_a  output  8  ALU a input
alu_b  output  8  ALU b input
alu_op  output  4  ALU op select
alu_c_in  output  1  ALU carry in
alu_dec_add  output  1  ALU decimal adjust; always 0
alu_own  output  1  high while this block drives the ALU
alu_out  input  8  ALU result (combinational, same cycle)
alu_carry_out  input  1  ALU carry out (combinational, same cycle)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, result/flags valid
result  output  16  word result, held until the next accepted start
n_out  output  1  result[15]
z_out  output  1  result == 16'h0000
c_out  output  1  final carry

Behaviour:
- Reset (async, reset_n=0): state=IDLE. busy, done, alu_own, result, n_out, z_out, c_out, alu_a, alu_b, alu_c_in, alu_dec_add are all 0. alu_op=OP_ADC.
- States: IDLE -> STEP1 -> STEP2 -> DONE -> IDLE.
- IDLE: on start=1, capture wop, operand and c_in, then go to STEP1. On start=0, stay.
- start in any other state is ignored; there is no queueing.
- STEP1 and STEP2: alu_own=1. Each step drives one byte to the ALU combinationally and latches alu_out and alu_carry_out at the clock edge ending that step. The STEP2 carry in is the carry latched at the end of STEP1 (the chain carry).
- Byte order: INW, DEW and ASW process low byte then high byte. ROW processes high byte then low byte.
- INW: op=OP_ADC, b=8'h00. STEP1 c_in=1.
- DEW: op=OP_ADC, b=8'hFF. STEP1 c_in=0.
- ASW: op=OP_ADC, b=a (same byte on both inputs). STEP1 c_in=0.
- ROW: op=OP_ROR, b=8'h00. STEP1 c_in=captured c_in.
- DONE: alu_own=0 and done=1 for exactly one cycle. result, n_out, z_out and c_out update at the edge entering DONE and hold afterward.
- c_out:
  - INW/ASW: carry out of the high byte.
  - DEW: carry out of the high byte (1 = no borrow; 0 only for 16'h0000 -> 16'hFFFF).
  - ROW: operand[0].
- Latency: start accepted at edge E0; STEP1 is E0..E1, STEP2 is E1..E2, done is high E2..E3. A new start is accepted in the cycle after DONE (earliest one every 4 cycles).
- When alu_own=0, alu_a, alu_b and alu_c_in are driven 0 and alu_op=OP_ADC, so the muxes see stable values.
- Wrap-around: 16'hFFFF INW -> 16'h0000 with Z=1, C=1.
- Reset asserted in STEP1, STEP2 or DONE: abort immediately to reset values. No done pulse; result is cleared.

Test Plan:
1. INW operand=16'h12FF -> done on the 3rd cycle after start; result=16'h1300, N=0, Z=0, C=0; STEP1 alu_a=FF, alu_c_in=1; STEP2 alu_a=12, alu_c_in=1.
2. INW operand=16'hFFFF -> result=16'h0000, Z=1, C=1. DEW operand=16'h0000 -> result=16'hFFFF, N=1, C=0.
3. ASW operand=16'h80C1 -> result=16'h0182, C=1. ROW operand=16'h0003, c_in=1 -> STEP1 alu_a=00, op=OP_ROR; result=16'h8001, C=1, N=1.
4. start held high continuously with INW 16'h0001 -> a single done per 4 cycles, busy low exactly one cycle between ops; a different operand presented while busy is not captured.
5. reset_n pulsed low during STEP2 of DEW 16'h1000 -> outputs zero asynchronously, no done pulse; after release, IDLE accepts a new start normally.
6. alu_own high only in STEP1/STEP2; alu_dec_add=0 in all states.

Source files
------------

// File: rtl/alu_word_seq.sv
// Sequences 16-bit INW/DEW/ASW/ROW through the shared 8-bit ALU.
// Two byte steps with carry chained between them, then a done pulse.
module alu_word_seq #(
   parameter logic [3:0] OP_ADC = 4'h3,
   parameter logic [3:0] OP_ROR = 4'h7
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  wop,
   input  logic [15:0] operand,
   input  logic        c_in,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [3:0]  alu_op,
   output logic        alu_c_in,
   output logic        alu_dec_add,
   output logic        alu_own,
   input  logic [7:0]  alu_out,
   input  logic        alu_carry_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        n_out,
   output logic        z_out,
   output logic        c_out
);

   typedef enum logic [1:0] {
      IDLE,
      STEP1,
      STEP2,
      DONE
   } state_t;

   localparam logic [1:0] W_INW = 2'd0;
   localparam logic [1:0] W_DEW = 2'd1;
   localparam logic [1:0] W_ASW = 2'd2;
   localparam logic [1:0] W_ROW = 2'd3;

   state_t      state;
   state_t      state_nx;
   logic [1:0]  wop_q;
   logic [15:0] opnd_q;
   logic        cin_q;
   logic [7:0]  byte1_q;
   logic        chain_q;
   logic        is_row;
   logic        low_sel;
   logic [7:0]  byte_sel;
   logic        first_c;
   logic [15:0] word_nx;

   assign is_row      = (wop_q == W_ROW);
   assign alu_own     = (state == STEP1) || (state == STEP2);
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign alu_dec_add = 1'b0;

   // ROW walks high byte first so the rotate carry moves downward
   assign low_sel  = (state == STEP1) ^ is_row;
   assign byte_sel = low_sel ? opnd_q[7:0] : opnd_q[15:8];
   assign word_nx  = is_row ? {byte1_q, alu_out}
                            : {alu_out, byte1_q};

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = STEP1;
         STEP1:   state_nx = STEP2;
         STEP2:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      first_c = 1'b0;
      unique case (wop_q)
         W_INW:   first_c = 1'b1;
         W_ROW:   first_c = cin_q;
         default: first_c = 1'b0;
      endcase
   end

   always_comb begin
      alu_a    = 8'h00;
      alu_b    = 8'h00;
      alu_op   = OP_ADC;
      alu_c_in = 1'b0;
      if (alu_own) begin
         alu_a    = byte_sel;
         alu_c_in = (state == STEP2) ? chain_q : first_c;
         unique case (wop_q)
            W_INW:   alu_b = 8'h00;
            W_DEW:   alu_b = 8'hFF;
            W_ASW:   alu_b = byte_sel;
            W_ROW:   alu_op = OP_ROR;
            default: alu_b = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         wop_q   <= 2'd0;
         opnd_q  <= 16'h0000;
         cin_q   <= 1'b0;
         byte1_q <= 8'h00;
         chain_q <= 1'b0;
         result  <= 16'h0000;
         n_out   <= 1'b0;
         z_out   <= 1'b0;
         c_out   <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               if (start) begin
                  wop_q  <= wop;
                  opnd_q <= operand;
                  cin_q  <= c_in;
               end
            end
            STEP1: begin
               byte1_q <= alu_out;
               chain_q <= alu_carry_out;
            end
            STEP2: begin
               result <= word_nx;
               n_out  <= word_nx[15];
               z_out  <= (word_nx == 16'h0000);
               c_out  <= alu_carry_out;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_word_seq.sv
// Random and directed bench for alu_word_seq with an external ALU model.
// Expected words are queued at issue and checked on each done pulse.
module tb_alu_word_seq;

   localparam logic [3:0] P_ADC = 4'h3;
   localparam logic [3:0] P_ROR = 4'h7;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  wop;
   logic [15:0] operand;
   logic        c_in;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [3:0]  alu_op;
   logic        alu_c_in;
   logic        alu_dec_add;
   logic        alu_own;
   logic [7:0]  alu_out;
   logic        alu_carry_out;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        n_out;
   logic        z_out;
   logic        c_out;

   typedef struct packed {
      logic [15:0] r;
      logic        c;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;

   alu_word_seq #(.OP_ADC(P_ADC), .OP_ROR(P_ROR)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .wop(wop),
      .operand(operand), .c_in(c_in), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .alu_c_in(alu_c_in), .alu_dec_add(alu_dec_add),
      .alu_own(alu_own), .alu_out(alu_out),
      .alu_carry_out(alu_carry_out), .busy(busy), .done(done),
      .result(result), .n_out(n_out), .z_out(z_out), .c_out(c_out)
   );

   always #5 clk = ~clk;

   // 8-bit ALU: add with carry, or rotate right through carry
   always_comb begin
      if (alu_op == P_ROR) begin
         alu_out       = {alu_c_in, alu_a[7:1]};
         alu_carry_out = alu_a[0];
      end else begin
         {alu_carry_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b}
                                  + {8'h00, alu_c_in};
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] w,
                                  input logic [15:0] d,
                                  input logic ci);
      exp_t e;
      logic [16:0] s;
      e = '0;
      case (w)
         2'd0: begin
            s = {1'b0, d} + 17'd1;
            e.r = s[15:0];
            e.c = s[16];
         end
         2'd1: begin
            e.r = d - 16'd1;
            e.c = (d != 16'h0000);
         end
         2'd2: begin
            e.r = {d[14:0], 1'b0};
            e.c = d[15];
         end
         default: begin
            e.r = {ci, d[15:1]};
            e.c = d[0];
         end
      endcase
      return e;
   endfunction

   always @(negedge clk) begin
      if (reset_n) begin
         chk("dec_add", {31'd0, alu_dec_add}, 32'd0);
         if (done) begin
            exp_t e;
            done_cnt++;
            if (q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("result", {16'd0, result}, {16'd0, e.r});
               chk("n_flag", {31'd0, n_out}, {31'd0, e.r[15]});
               chk("z_flag", {31'd0, z_out},
                   {31'd0, (e.r == 16'h0000)});
               chk("c_flag", {31'd0, c_out}, {31'd0, e.c});
            end
         end
      end
   end

   // called on a negedge; returns on the negedge inside STEP1
   task automatic issue(input logic [1:0] w, input logic [15:0] d,
                        input logic ci);
      int t = 0;
      while (busy && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (busy) chk("issue_timeout", 32'd1, 32'd0);
      wop     = w;
      operand = d;
      c_in    = ci;
      start   = 1'b1;
      q.push_back(model(w, d, ci));
      @(negedge clk);
      start   = 1'b0;
      operand = 16'($urandom);
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((busy || q.size() != 0) && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (t >= 40) chk("idle_timeout", 32'd1, 32'd0);
      @(negedge clk);
   endtask

   initial begin
      logic [15:0] special [6];
      int idle_n;
      int done_n;
      int dc;
      special[0] = 16'h0000;
      special[1] = 16'hFFFF;
      special[2] = 16'h8000;
      special[3] = 16'h00FF;
      special[4] = 16'hFF00;
      special[5] = 16'h0001;
      reset_n = 1'b0;
      start   = 1'b0;
      wop     = 2'd0;
      operand = 16'h0000;
      c_in    = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_own", {31'd0, alu_own}, 32'd0);
      chk("rst_result", {16'd0, result}, 32'd0);
      chk("rst_zc", {30'd0, z_out, c_out}, 32'd0);
      chk("rst_alu_op", {28'd0, alu_op}, {28'd0, P_ADC});
      reset_n = 1'b1;
      @(negedge clk);

      issue(2'd0, 16'h12FF, 1'b0);
      chk("inw_s1_own", {31'd0, alu_own}, 32'd1);
      chk("inw_s1_a", {24'd0, alu_a}, 32'h0FF);
      chk("inw_s1_cin", {31'd0, alu_c_in}, 32'd1);
      chk("inw_s1_op", {28'd0, alu_op}, {28'd0, P_ADC});
      @(negedge clk);
      chk("inw_s2_a", {24'd0, alu_a}, 32'h012);
      chk("inw_s2_cin", {31'd0, alu_c_in}, 32'd1);
      @(negedge clk);
      chk("inw_done", {31'd0, done}, 32'd1);
      chk("inw_done_own", {31'd0, alu_own}, 32'd0);
      chk("inw_done_a", {24'd0, alu_a}, 32'd0);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("result_hold", {16'd0, result}, 32'h1300);
      chk("idle_own", {31'd0, alu_own}, 32'd0);

      issue(2'd0, 16'hFFFF, 1'b0);
      wait_idle();
      issue(2'd1, 16'h0000, 1'b0);
      wait_idle();
      issue(2'd2, 16'h80C1, 1'b0);
      wait_idle();
      issue(2'd3, 16'h0003, 1'b1);
      chk("row_s1_a", {24'd0, alu_a}, 32'd0);
      chk("row_s1_op", {28'd0, alu_op}, {28'd0, P_ROR});
      wait_idle();

      idle_n = 0;
      done_n = 0;
      start  = 1'b1;
      wop    = 2'd0;
      for (int i = 0; i < 12; i++) begin
         if (!busy) begin
            operand = 16'h0001;
            q.push_back(model(2'd0, 16'h0001, 1'b0));
            idle_n++;
         end else begin
            operand = 16'($urandom);
         end
         if (done) done_n++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("hold_idle_cycles", idle_n, 32'd3);
      chk("hold_done_count", done_n, 32'd3);
      wait_idle();

      issue(2'd1, 16'h1000, 1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_own", {31'd0, alu_own}, 32'd0);
      chk("abort_result", {16'd0, result}, 32'd0);
      chk("abort_flags", {29'd0, n_out, z_out, c_out}, 32'd0);
      chk("abort_alu_a", {24'd0, alu_a}, 32'd0);
      q.delete();
      dc = done_cnt;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("abort_no_done", done_cnt, dc);
      issue(2'd0, 16'h00FF, 1'b0);
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         logic [15:0] d;
         d = ($urandom_range(0, 3) == 0)
           ? special[$urandom_range(0, 5)] : 16'($urandom);
         issue(2'($urandom_range(0, 3)), d, 1'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
